// File: rtl/cordic_atan2_mag_if.sv
// cordic_atan2_mag_if: request/result bundle for the atan2/magnitude CORDIC engine
interface cordic_atan2_mag_if;
    logic              i_start;
    logic signed [8:0] i_x_in;
    logic signed [8:0] i_y_in;
    logic        [8:0] o_angle_out;
    logic        [8:0] o_mag_out;
    logic              o_busy;
    logic              o_done;

    modport master (output i_start, i_x_in, i_y_in, input o_angle_out, o_mag_out, o_busy, o_done);
    modport slave  (input i_start, i_x_in, i_y_in, output o_angle_out, o_mag_out, o_busy, o_done);
endinterface

// File: rtl/cordic_atan2_mag.sv
// cordic_atan2_mag: iterative vectoring CORDIC, signed (x,y) -> whole-degree angle and gain-compensated magnitude
module cordic_atan2_mag #(
    parameter int I_MAX  = 8,
    parameter int GAIN_K = 155
) (
    input  logic               clk,
    input  logic               reset,
    cordic_atan2_mag_if.slave  bus
);
    localparam int IW = (I_MAX > 1) ? $clog2(I_MAX) : 1;
    localparam logic signed [11:0] T [8] = '{12'sd360, 12'sd213, 12'sd112, 12'sd57,
                                             12'sd29, 12'sd14, 12'sd7, 12'sd4};

    typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

    state_t            r_state;
    logic [IW-1:0]     r_i;
    logic signed [11:0] r_x, r_y, r_z;
    logic              r_qx, r_qy, r_zero, r_yaxis;

    logic [9:0]        w_xs, w_ys, w_ax, w_ay;
    logic signed [11:0] w_dx, w_dy, w_t, w_ar;
    logic [6:0]        w_a;
    logic [8:0]        w_ae, w_ang, w_angle, w_mag;
    logic [19:0]       w_prod;

    always_comb begin
        w_xs    = {bus.i_x_in[8], bus.i_x_in};
        w_ys    = {bus.i_y_in[8], bus.i_y_in};
        w_ax    = w_xs[9] ? -w_xs : w_xs;
        w_ay    = w_ys[9] ? -w_ys : w_ys;
        w_dx    = r_x >>> r_i;
        w_dy    = r_y >>> r_i;
        w_t     = T[r_i];
        w_ar    = (r_z + 12'sd4) >>> 3;
        // y==0 would otherwise round the half-degree residual of the last micro-rotation up to 1
        w_a     = (w_ar[11] || r_yaxis) ? 7'd0 : (w_ar > 12'sd90) ? 7'd90 : w_ar[6:0];
        w_ae    = {2'b00, w_a};
        w_ang   = !r_qx ? (!r_qy ? w_ae : 9'd360 - w_ae) : (!r_qy ? 9'd180 - w_ae : 9'd180 + w_ae);
        w_angle = (w_ang == 9'd360) ? 9'd0 : w_ang;
        w_prod  = {8'd0, r_x} * 20'(GAIN_K);
        w_mag   = |w_prod[19:17] ? 9'd511 : w_prod[16:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_i             <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_z             <= '0;
            r_qx            <= 1'b0;
            r_qy            <= 1'b0;
            r_zero          <= 1'b0;
            r_yaxis         <= 1'b0;
            bus.o_angle_out <= '0;
            bus.o_mag_out   <= '0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.i_start) begin
                    r_x        <= {2'b00, w_ax};
                    r_y        <= {2'b00, w_ay};
                    r_z        <= '0;
                    r_i        <= '0;
                    r_qx       <= bus.i_x_in[8];
                    r_qy       <= bus.i_y_in[8];
                    r_zero     <= (bus.i_x_in == 9'sd0) && (bus.i_y_in == 9'sd0);
                    r_yaxis    <= bus.i_y_in == 9'sd0;
                    bus.o_busy <= 1'b1;
                    r_state    <= ITER;
                end
                ITER: begin
                    r_x <= r_y[11] ? r_x - w_dy : r_x + w_dy;
                    r_y <= r_y[11] ? r_y + w_dx : r_y - w_dx;
                    r_z <= r_y[11] ? r_z - w_t : r_z + w_t;
                    r_i <= r_i + IW'(1);
                    if (r_i == IW'(I_MAX - 1)) r_state <= FINAL;
                end
                FINAL: begin
                    bus.o_angle_out <= r_zero ? 9'd0 : w_angle;
                    bus.o_mag_out   <= r_zero ? 9'd0 : w_mag;
                    bus.o_done      <= 1'b1;
                    bus.o_busy      <= 1'b0;
                    r_state         <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_atan2_mag.sv
// tb_cordic_atan2_mag: directed vectors, handshake/reset cases and a radius-200 sweep against hand-derived angles
`timescale 1ns/1ps
module tb_cordic_atan2_mag;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    cordic_atan2_mag_if u_if();

    cordic_atan2_mag u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp, input int tol, input bit wrap);
        int d;
        d = got - exp;
        if (wrap) d = ((d % 360) + 540) % 360 - 180;
        n_chk++;
        if (d <= tol && d >= -tol) n_pass++;
        else $display("FAIL %s: got %0d want %0d tol %0d", tag, got, exp, tol);
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // call at #1 after a posedge with the engine idle; returns at the cycle done is seen
    task automatic convert(input int x, input int y, output int ang, output int mag,
                           output int lat, output int nbusy);
        u_if.i_x_in  = 9'(x);
        u_if.i_y_in  = 9'(y);
        u_if.i_start = 1'b1;
        @(posedge clk); #1;
        u_if.i_start = 1'b0;
        u_if.i_x_in  = 9'($urandom);
        u_if.i_y_in  = 9'($urandom);
        nbusy = u_if.o_busy ? 1 : 0;
        lat   = 0;
        while (!u_if.o_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (u_if.o_busy) nbusy++;
        end
        ang = int'(u_if.o_angle_out);
        mag = int'(u_if.o_mag_out);
    endtask

    initial begin
        int ang, mag, lat, nb, nd, cnt;
        int t [3];
        n_chk        = 0;
        n_pass       = 0;
        reset        = 1'b1;
        u_if.i_start = 1'b0;
        u_if.i_x_in  = '0;
        u_if.i_y_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_angle", int'(u_if.o_angle_out), 0, 0, 0);
        chk("rst_mag", int'(u_if.o_mag_out), 0, 0, 0);
        chk("rst_busy", int'(u_if.o_busy), 0, 0, 0);
        chk("rst_done", int'(u_if.o_done), 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        convert(100, 0, ang, mag, lat, nb);
        chk("x100_lat", lat, 9, 0, 0);
        chk("x100_busy", nb, 9, 0, 0);
        chk("x100_busy_at_done", int'(u_if.o_busy), 0, 0, 0);
        chk("x100_angle", ang, 0, 0, 0);
        chk("x100_mag", mag, 100, 2, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", int'(u_if.o_done), 0, 0, 0);
        chk("angle_hold", int'(u_if.o_angle_out), 0, 0, 0);

        convert(0, 100, ang, mag, lat, nb);
        chk("y100_angle", ang, 90, 1, 1);
        chk("y100_mag", mag, 100, 2, 0);
        convert(-100, -100, ang, mag, lat, nb);
        chk("q3_angle", ang, 225, 1, 1);
        chk("q3_mag", mag, 141, 3, 0);
        convert(0, -50, ang, mag, lat, nb);
        chk("ym50_angle", ang, 270, 1, 1);
        chk("ym50_mag", mag, 50, 2, 0);
        convert(-256, 0, ang, mag, lat, nb);
        chk("xm256_angle", ang, 180, 1, 1);
        chk("xm256_mag", mag, 256, 6, 0);
        convert(-256, -256, ang, mag, lat, nb);
        chk("corner_angle", ang, 225, 1, 1);
        chk("corner_mag", mag, 362, 8, 0);
        convert(0, 0, ang, mag, lat, nb);
        chk("zero_lat", lat, 9, 0, 0);
        chk("zero_angle", ang, 0, 0, 0);
        chk("zero_mag", mag, 0, 0, 0);

        u_if.i_x_in  = 9'sd100;
        u_if.i_y_in  = 9'sd100;
        u_if.i_start = 1'b1;
        @(posedge clk); #1;
        u_if.i_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        u_if.i_x_in  = -9'sd100;
        u_if.i_y_in  = 9'sd0;
        u_if.i_start = 1'b1;
        @(posedge clk); #1;
        u_if.i_start = 1'b0;
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (u_if.o_done) begin
                nd++;
                ang = int'(u_if.o_angle_out);
                mag = int'(u_if.o_mag_out);
            end
        end
        chk("ignore_start_dones", nd, 1, 0, 0);
        chk("ignore_start_angle", ang, 45, 1, 1);
        chk("ignore_start_mag", mag, 141, 3, 0);

        u_if.i_x_in  = 9'sd0;
        u_if.i_y_in  = 9'sd100;
        u_if.i_start = 1'b1;
        cnt = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            if (u_if.o_done) begin
                if (cnt < 3) t[cnt] = c;
                cnt++;
                ang = int'(u_if.o_angle_out);
            end
        end
        u_if.i_start = 1'b0;
        chk("b2b_count", cnt, 3, 0, 0);
        chk("b2b_gap1", t[1] - t[0], 10, 0, 0);
        chk("b2b_gap2", t[2] - t[1], 10, 0, 0);
        chk("b2b_angle", ang, 90, 1, 1);
        repeat (12) begin @(posedge clk); #1; end

        u_if.i_x_in  = -9'sd100;
        u_if.i_y_in  = -9'sd100;
        u_if.i_start = 1'b1;
        @(posedge clk); #1;
        u_if.i_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", int'(u_if.o_busy), 0, 0, 0);
        chk("abort_done", int'(u_if.o_done), 0, 0, 0);
        chk("abort_angle", int'(u_if.o_angle_out), 0, 0, 0);
        chk("abort_mag", int'(u_if.o_mag_out), 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (u_if.o_done || u_if.o_busy) nd++;
        end
        chk("abort_no_done", nd, 0, 0, 0);

        for (int d = 0; d < 360; d++) begin
            real r;
            r = real'(d) * 3.14159265358979 / 180.0;
            convert(rnd(200.0 * $cos(r)), rnd(200.0 * $sin(r)), ang, mag, lat, nb);
            chk($sformatf("sweep%0d_angle", d), ang, d, 1, 1);
            chk($sformatf("sweep%0d_mag", d), mag, 200, 5, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
